dac_controller: RTL and testbench
=================================

DAC_CONTROLLER -- requirements
Module: dac_controller

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset. Clock port is i_BCLK and reset port is i_rst_n. All state updates SHALL occur on posedge i_BCLK.
REQ-002 Ports:
- i_BCLK  in  1  codec bit clock; sole clock
- i_rst_n  in  1  async active-low reset
- i_play  in  1  playback enable, level
- i_DACLRCK  in  1  codec DAC LR clock (low = left, high = right)
- i_DATA  in  16  signed sample to play
- i_valid  in  1  i_DATA valid
- o_ready  out  1  block accepts i_DATA this cycle
- o_DACDAT  out  1  serial data to codec, MSB first
- o_done  out  1  one-cycle pulse, frame (L+R) fully sent
- o_underrun  out  1  one-cycle pulse, frame started with empty buffer
- o_PLAY_STATE  out  3  current state encoding

Function
REQ-003 States SHALL be S_IDLE=0, S_WAIT_L=1, S_WRITE_L=2, S_WAIT_R=3, S_WRITE_R=4. o_PLAY_STATE SHALL equal the registered state.
REQ-004 The block SHALL keep a registered copy of i_DACLRCK (pre_LRCK) each cycle. A falling edge is pre_LRCK=1 and i_DACLRCK=0. A rising edge is pre_LRCK=0 and i_DACLRCK=1.
REQ-005 The block SHALL hold a one-entry sample buffer (buf, buf_valid). o_ready SHALL equal i_play AND NOT buf_valid.
REQ-006 When i_valid and o_ready are both high at a posedge, the block SHALL store i_DATA into buf and set buf_valid.
REQ-007 S_IDLE: o_DACDAT=0. The block SHALL go to S_WAIT_L when i_play=1.
REQ-008 S_WAIT_L, on a falling edge of i_DACLRCK:
- next state S_WRITE_L, bit counter cleared.
- If buf_valid, the shift register SHALL load buf and buf_valid SHALL clear.
- Otherwise the shift register SHALL load 16'h0000 and o_underrun SHALL pulse high for the next cycle.
REQ-009 S_WRITE_L and S_WRITE_R: o_DACDAT SHALL equal shift[15]. Each cycle the block SHALL shift left one bit and increment the 4-bit counter. On counter=15 it SHALL leave the state.
- First bit driven is the MSB, in the cycle immediately after edge detection.
REQ-010 Leaving S_WRITE_L SHALL go to S_WAIT_R. The same sample SHALL be retained for the right channel (mono duplicated).
REQ-011 S_WAIT_R, on a rising edge of i_DACLRCK: the block SHALL reload the shift register with the left-channel sample, clear the counter, and go to S_WRITE_R.
REQ-012 Leaving S_WRITE_R SHALL go to S_WAIT_L and set o_done high for exactly one cycle.
REQ-013 In S_WAIT_L and S_WAIT_R, o_DACDAT SHALL be 0.
REQ-014 If i_play=0 in any state, the next state SHALL be S_IDLE.
- The frame in progress is aborted: o_DACDAT becomes 0, buf_valid clears, and o_done does not pulse.
REQ-015 If an accept (REQ-006) and an underrun load (REQ-008) occur in the same cycle, the underrun SHALL be reported and the accepted word SHALL be kept for the next frame.
REQ-016 Edges of i_DACLRCK outside the matching WAIT state SHALL be ignored.

Reset
REQ-017 While i_rst_n=0 the block SHALL immediately hold:
- state=S_IDLE, shift=0, counter=0, buf=0, buf_valid=0, pre_LRCK=0
- o_DACDAT=0, o_done=0, o_underrun=0, o_ready=0
REQ-018 Reset asserted mid-frame SHALL abort the frame with no o_done pulse. Normal operation SHALL resume from S_IDLE on the first posedge after release.

Structure
REQ-019 A shared package audio_pkg SHALL hold:
- the state enum
- SAMPLE_W=16
- BITCNT_W=4
REQ-020 The block SHALL instantiate one sub-module, lrck_edge_detect. It outputs one-cycle rise and fall strobes from i_DACLRCK on i_BCLK and is reusable by the ADC side.

Verification
REQ-021 Sample 16'hA5C3 accepted, then an LRCK fall → o_DACDAT = 1010010111000011 over 16 cycles; after the LRCK rise the same 16 bits again; then o_done pulses once.
REQ-022 No sample supplied at an LRCK fall → o_underrun pulses once and 16 zero bits are sent left and right; o_done still pulses.
REQ-023 Back-to-back 16'h8001 then 16'h7FFE, each offered when o_ready=1 → consecutive frames carry the exact values and o_underrun never pulses.
REQ-024 i_play dropped at bit 7 of the left channel → next cycle o_PLAY_STATE=0, o_DACDAT=0, o_ready=0, and no o_done.
REQ-025 i_rst_n pulsed low during S_WRITE_R → outputs go to zero asynchronously; after release with i_play=1, the next LRCK fall starts a fresh frame.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-path definitions: play-state encoding and sample/bit-counter widths.
package audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam int BITCNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_L  = 3'd1,
    S_WRITE_L = 3'd2,
    S_WAIT_R  = 3'd3,
    S_WRITE_R = 3'd4
  } play_state_e;

endpackage

// File: rtl/dac_controller_if.sv
// Sample stream handshake into the DAC controller (valid/ready, one word per accept).
interface dac_controller_if;
  import audio_pkg::*;

  logic [SAMPLE_W-1:0] i_DATA;
  logic                i_valid;
  logic                o_ready;

  modport master (output i_DATA, output i_valid, input o_ready);
  modport slave  (input i_DATA, input i_valid, output o_ready);

endinterface

// File: rtl/lrck_edge_detect.sv
// One-cycle rise/fall strobes of an LR clock sampled on the bit clock; shared by DAC and ADC paths.
module lrck_edge_detect (
  input  logic i_BCLK,
  input  logic i_rst_n,
  input  logic i_lrck,
  output logic o_rise,
  output logic o_fall
);

  logic pre_lrck;

  always_ff @(posedge i_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) pre_lrck <= 1'b0;
    else          pre_lrck <= i_lrck;
  end

  assign o_rise = ~pre_lrck &  i_lrck;
  assign o_fall =  pre_lrck & ~i_lrck;

endmodule

// File: rtl/dac_controller.sv
// Mono DAC serializer: buffers one sample and sends it MSB-first on both LRCK halves.
//   state     | meaning
//   S_IDLE    | playback off, output held low
//   S_WAIT_L  | waiting for LRCK fall to start the left word
//   S_WRITE_L | shifting the left word
//   S_WAIT_R  | waiting for LRCK rise to start the right word
//   S_WRITE_R | shifting the right word (same sample as left)
module dac_controller
  import audio_pkg::*;
(
  input  logic            i_BCLK,
  input  logic            i_rst_n,
  input  logic            i_play,
  input  logic            i_DACLRCK,
  dac_controller_if.slave smp,
  output logic            o_DACDAT,
  output logic            o_done,
  output logic            o_underrun,
  output logic [2:0]      o_PLAY_STATE
);

  localparam logic [BITCNT_W-1:0] BIT_LAST = BITCNT_W'(SAMPLE_W - 1);
  localparam logic [BITCNT_W-1:0] BIT_ONE  = BITCNT_W'(1);

  play_state_e         state, state_nxt;
  logic [SAMPLE_W-1:0] shift_q, shift_nxt;
  logic [SAMPLE_W-1:0] cur_q, cur_nxt;
  logic [SAMPLE_W-1:0] buf_q, buf_nxt;
  logic                buf_valid_q, buf_valid_nxt;
  logic [BITCNT_W-1:0] cnt_q, cnt_nxt;
  logic                done_nxt, underrun_nxt;
  logic                lrck_rise, lrck_fall;
  logic                accept;

  lrck_edge_detect u_lrck_edge (
    .i_BCLK  (i_BCLK),
    .i_rst_n (i_rst_n),
    .i_lrck  (i_DACLRCK),
    .o_rise  (lrck_rise),
    .o_fall  (lrck_fall)
  );

  // Reset gates ready directly so the port reads low while reset is held.
  assign smp.o_ready = i_rst_n & i_play & ~buf_valid_q;
  assign accept      = smp.i_valid & smp.o_ready;

  always_ff @(posedge i_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      shift_q     <= '0;
      cur_q       <= '0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      cnt_q       <= '0;
      o_done      <= 1'b0;
      o_underrun  <= 1'b0;
    end else begin
      state       <= state_nxt;
      shift_q     <= shift_nxt;
      cur_q       <= cur_nxt;
      buf_q       <= buf_nxt;
      buf_valid_q <= buf_valid_nxt;
      cnt_q       <= cnt_nxt;
      o_done      <= done_nxt;
      o_underrun  <= underrun_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    shift_nxt     = shift_q;
    cur_nxt       = cur_q;
    buf_nxt       = buf_q;
    buf_valid_nxt = buf_valid_q;
    cnt_nxt       = cnt_q;
    done_nxt      = 1'b0;
    underrun_nxt  = 1'b0;

    // An accept can coincide with an underrun load; the new word then waits for the next frame.
    if (accept) begin
      buf_nxt       = smp.i_DATA;
      buf_valid_nxt = 1'b1;
    end

    if (!i_play) begin
      state_nxt     = S_IDLE;
      buf_valid_nxt = 1'b0;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_WAIT_L;
        S_WAIT_L: begin
          if (lrck_fall) begin
            state_nxt = S_WRITE_L;
            cnt_nxt   = '0;
            if (buf_valid_q) begin
              shift_nxt     = buf_q;
              cur_nxt       = buf_q;
              buf_valid_nxt = 1'b0;
            end else begin
              shift_nxt    = '0;
              cur_nxt      = '0;
              underrun_nxt = 1'b1;
            end
          end
        end
        S_WRITE_L: begin
          shift_nxt = {shift_q[SAMPLE_W-2:0], 1'b0};
          cnt_nxt   = cnt_q + BIT_ONE;
          if (cnt_q == BIT_LAST) state_nxt = S_WAIT_R;
        end
        S_WAIT_R: begin
          if (lrck_rise) begin
            state_nxt = S_WRITE_R;
            shift_nxt = cur_q;
            cnt_nxt   = '0;
          end
        end
        S_WRITE_R: begin
          shift_nxt = {shift_q[SAMPLE_W-2:0], 1'b0};
          cnt_nxt   = cnt_q + BIT_ONE;
          if (cnt_q == BIT_LAST) begin
            state_nxt = S_WAIT_L;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign o_DACDAT     = ((state == S_WRITE_L) || (state == S_WRITE_R)) ? shift_q[SAMPLE_W-1] : 1'b0;
  assign o_PLAY_STATE = state;

endmodule

// File: tb/tb_dac_controller.sv
// Bench for dac_controller: frame-level reference model checked every cycle, directed scenarios plus random traffic.
module tb_dac_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        play;
  logic        lrck;
  logic        dacdat, done, underrun;
  logic [2:0]  play_state;

  dac_controller_if smp();

  dac_controller dut (
    .i_BCLK       (clk),
    .i_rst_n      (rst_n),
    .i_play       (play),
    .i_DACLRCK    (lrck),
    .smp          (smp),
    .o_DACDAT     (dacdat),
    .o_done       (done),
    .o_underrun   (underrun),
    .o_PLAY_STATE (play_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 wait-left, 2 send-left, 3 wait-right, 4 send-right.
  int          m_phase = 0;
  int          m_bit   = 0;
  logic [15:0] m_sample = '0;
  logic [15:0] m_fifo[$];
  logic        m_prev = 1'b0;
  logic        m_done = 1'b0;
  logic        m_under = 1'b0;
  logic        m_fall, m_rise, m_take;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_bit = 0; m_sample = '0; m_prev = 1'b0;
      m_done = 1'b0; m_under = 1'b0;
      m_fifo.delete();
    end else begin
      m_fall  = m_prev & ~lrck;
      m_rise  = ~m_prev & lrck;
      m_prev  = lrck;
      m_take  = play && smp.i_valid && (m_fifo.size() == 0);
      m_done  = 1'b0;
      m_under = 1'b0;
      if (!play) begin
        m_phase = 0;
        m_fifo.delete();
      end else begin
        if (m_phase == 0) m_phase = 1;
        else if (m_phase == 1) begin
          if (m_fall) begin
            if (m_fifo.size() > 0) m_sample = m_fifo.pop_front();
            else begin m_sample = '0; m_under = 1'b1; end
            m_bit = 0; m_phase = 2;
          end
        end else if (m_phase == 2) begin
          m_bit++;
          if (m_bit == 16) m_phase = 3;
        end else if (m_phase == 3) begin
          if (m_rise) begin m_bit = 0; m_phase = 4; end
        end else begin
          m_bit++;
          if (m_bit == 16) begin m_phase = 1; m_done = 1'b1; end
        end
        if (m_take) m_fifo.push_back(smp.i_DATA);
      end
    end
  end

  logic        exp_dat;
  logic [15:0] cap = '0;
  logic [15:0] last_l = 16'hDEAD;
  logic [15:0] last_r = 16'hDEAD;
  int          done_cnt = 0;
  int          under_cnt = 0;

  always @(negedge clk) begin
    exp_dat = (m_phase == 2 || m_phase == 4) ? m_sample[15 - m_bit] : 1'b0;
    chk("dacdat", 32'(dacdat), 32'(exp_dat));
    chk("state", 32'(play_state), m_phase);
    chk("ready", 32'(smp.o_ready), 32'(rst_n && play && (m_fifo.size() == 0)));
    chk("done", 32'(done), 32'(m_done));
    chk("underrun", 32'(underrun), 32'(m_under));
    if (done) done_cnt++;
    if (underrun) under_cnt++;
    if (m_phase == 2 || m_phase == 4) begin
      cap = {cap[14:0], dacdat};
      if (m_bit == 15) begin
        if (m_phase == 2) last_l = cap;
        else last_r = cap;
      end
    end
  end

  // Stimulus: LRCK divider and a source queue feeding the valid/ready handshake.
  logic [15:0] src[$];
  int          lr_half = 24;
  int          lr_cnt = 0;
  bit          lr_rand = 0;

  task automatic step();
    logic acc;
    #1;
    acc = smp.i_valid && smp.o_ready;
    @(posedge clk);
    #2;
    lr_cnt++;
    if (lr_cnt >= lr_half) begin
      lrck = ~lrck;
      lr_cnt = 0;
      if (lr_rand) lr_half = $urandom_range(4, 24);
    end
    if (acc) begin
      void'(src.pop_front());
      smp.i_valid = 1'b0;
    end
    if (!smp.i_valid && src.size() > 0) begin
      smp.i_valid = 1'b1;
      smp.i_DATA  = src[0];
    end
  endtask

  task automatic wait_done(input string nm, input int limit);
    bit got = 0;
    for (int i = 0; i < limit && !got; i++) begin
      step();
      if (done) got = 1;
    end
    chk(nm, 32'(got), 32'd1);
  endtask

  task automatic wait_phase(input string nm, input int ph, input int bt, input int limit);
    bit got = 0;
    for (int i = 0; i < limit && !got; i++) begin
      step();
      if (m_phase == ph && m_bit == bt) got = 1;
    end
    chk(nm, 32'(got), 32'd1);
  endtask

  int d0;

  initial begin
    rst_n = 1'b0; play = 1'b1; lrck = 1'b1;
    smp.i_valid = 1'b0; smp.i_DATA = '0;
    repeat (2) step();
    chk("rst_state_lit", 32'(play_state), 32'd0);
    chk("rst_ready_lit", 32'(smp.o_ready), 32'd0);
    chk("rst_dacdat_lit", 32'(dacdat), 32'd0);
    rst_n = 1'b1;

    src.push_back(16'hA5C3);
    wait_done("a5c3_done_seen", 300);
    step();
    chk("a5c3_left_lit", 32'(last_l), 32'hA5C3);
    chk("a5c3_right_lit", 32'(last_r), 32'hA5C3);
    chk("a5c3_done_cnt", done_cnt, 1);
    chk("a5c3_no_underrun", under_cnt, 0);

    last_l = 16'hDEAD; last_r = 16'hDEAD;
    wait_done("under_done_seen", 300);
    step();
    chk("under_left_lit", 32'(last_l), 32'h0);
    chk("under_right_lit", 32'(last_r), 32'h0);
    chk("under_cnt", under_cnt, 1);
    chk("under_done_cnt", done_cnt, 2);

    src.push_back(16'h8001);
    src.push_back(16'h7FFE);
    wait_done("b2b1_done_seen", 300);
    chk("b2b1_left_lit", 32'(last_l), 32'h8001);
    chk("b2b1_right_lit", 32'(last_r), 32'h8001);
    wait_done("b2b2_done_seen", 300);
    step();
    chk("b2b2_left_lit", 32'(last_l), 32'h7FFE);
    chk("b2b2_right_lit", 32'(last_r), 32'h7FFE);
    chk("b2b_no_underrun", under_cnt, 1);

    wait_phase("abort_reach_bit7", 2, 7, 300);
    play = 1'b0;
    step();
    chk("abort_state_lit", 32'(play_state), 32'd0);
    chk("abort_dacdat_lit", 32'(dacdat), 32'd0);
    chk("abort_ready_lit", 32'(smp.o_ready), 32'd0);
    d0 = done_cnt;
    repeat (60) step();
    chk("abort_no_done", done_cnt, d0);

    play = 1'b1;
    wait_phase("rst_reach_write_r", 4, 3, 300);
    rst_n = 1'b0;
    #1;
    chk("arst_dacdat_lit", 32'(dacdat), 32'd0);
    chk("arst_done_lit", 32'(done), 32'd0);
    chk("arst_underrun_lit", 32'(underrun), 32'd0);
    chk("arst_ready_lit", 32'(smp.o_ready), 32'd0);
    chk("arst_state_lit", 32'(play_state), 32'd0);
    src.push_back(16'h3C5A);
    repeat (2) step();
    rst_n = 1'b1;
    last_l = 16'hDEAD; last_r = 16'hDEAD;
    wait_done("fresh_done_seen", 300);
    chk("fresh_left_lit", 32'(last_l), 32'h3C5A);
    chk("fresh_right_lit", 32'(last_r), 32'h3C5A);

    lr_rand = 1;
    for (int i = 0; i < 4000; i++) begin
      if (play && $urandom_range(0, 399) == 0) play = 1'b0;
      else if (!play && $urandom_range(0, 19) == 0) play = 1'b1;
      if (src.size() == 0 && $urandom_range(0, 3) == 0) src.push_back(16'($urandom));
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
